store_buffer: RTL and testbench
===============================

# store_buffer

Write-side counterpart of the MEM-stage load formatter. It takes committed stores (SB/SH/SW/SWL/SWR) from the MEM stage and converts register data plus address offset into byte-lane write data and byte enables. It queues the formatted stores in an in-order FIFO and drains them to the data-memory port over a req/ack handshake. It also flags loads whose word address matches a pending store so the pipeline can stall them.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset; clears all entries
- st_valid  in  1  store request from MEM stage
- st_kind  in  3  0=SB, 1=SH, 2=SW, 3=SWL, 4=SWR; 5–7 reserved, treated as SW
- st_paddr  in  32  physical byte address
- st_wdata  in  32  unformatted source register (rt)
- st_uncached  in  1  store targets the uncached port
- st_ready  out  1  buffer can accept a store this cycle
- bus_req  out  1  head entry valid and presented
- bus_addr  out  32  head word address, bits [1:0] = 0
- bus_wrdata  out  32  head lane-formatted data
- bus_byteenable  out  4  head byte enables
- bus_uncached  out  1  head uncached flag
- bus_ack  in  1  memory accepted head this cycle
- load_paddr  in  32  address of load in MEM stage
- load_hit  out  1  a pending entry has the same word address
- empty  out  1  no entries
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Formatting is combinational on the input side and is written into the entry. Let off = st_paddr[1:0] and r = st_wdata.
  - SB: be = 4'b0001 << off; data = {4{r[7:0]}}.
  - SH: be = off[1] ? 4'b1100 : 4'b0011; data = {2{r[15:0]}}; off[0] ignored.
  - SW: be = 4'b1111; data = r; off ignored.
  - SWL: be = (4'b0010 << off) − 1, i.e. 0001/0011/0111/1111; data = r >> ((3−off)*8).
  - SWR: be = 4'b1111 << off, truncated to 4 bits, i.e. 1111/1110/1100/1000; data = r << (off*8).
- Misaligned SH/SW is excepted upstream and never reaches this block.
- Entry fields: {addr[31:2], data, be, uncached}. Storage is a circular FIFO with read pointer, write pointer and count.
- Push occurs when st_valid && st_ready. st_ready = (count < DEPTH). A pop in the same cycle does not raise st_ready, so there is no full-bypass path.
- Pop occurs when bus_req && bus_ack. The head advances and its entry is invalidated.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- bus_req = !empty. All bus_* outputs come from the head entry register and are not modified by pushes.
- load_hit = OR over valid entries of (entry.addr == load_paddr[31:2]).
  - A head being acked this cycle is still counted.
  - A store being pushed this cycle is not counted; the pipeline orders push before the younger load.
- Strict in-order drain. No merging or coalescing.

## Timing
- Reset state: count=0, empty=1, st_ready=1, bus_req=0, load_hit=0, pointers=0.
- bus_addr, bus_wrdata, bus_byteenable and bus_uncached are 0 while empty, including at reset.
- Reset asserted mid-transfer discards all entries immediately. A bus_ack during reset is ignored.
- Push-to-bus latency: a store pushed at edge N appears on bus_req after edge N, i.e. 1 cycle when the buffer was empty.
- Throughput: 1 push and 1 pop per cycle sustained. With bus_ack held high, a single store occupies the bus for exactly one cycle.
- Handshake: once bus_req rises, the bus_* values are stable until the cycle bus_ack=1. bus_ack while bus_req=0 is ignored.
- Full: st_ready=0 and count=DEPTH. st_valid while not ready has no effect; the pipeline stalls.
- st_ready, empty and count are registered-state functions with no combinational path from st_valid. load_hit is combinational from load_paddr only.

## Test plan
- Reset, then SB to 0x1000_0003 with r=0xAABBCCDD -> next cycle bus_req=1, addr=0x1000_0000, be=1000, data=0xDDDDDDDD; ack -> empty=1.
- SWL and SWR at each off 0–3 with r=0x11223344 -> SWL off1: be=0011, data=0x00001122. SWR off2: be=1100, data=0x33440000. All other offsets match the formulas.
- bus_ack held 0 while pushing DEPTH stores -> st_ready falls after the 4th push and count=4. A 5th st_valid is not accepted. After one ack, st_ready=1 the next cycle.
- Pushes with bus_ack=1 every cycle -> count stays ≤1, entries drain in push order, and pointer wrap is exercised past 2×DEPTH stores.
- Pending SH at 0x2000_0006 -> load_paddr=0x2000_0004 gives load_hit=1; 0x2000_0008 gives 0. After the ack cycle, load_hit=0.
- Assert rst asynchronously with 3 entries queued and bus_ack=1 -> outputs reach reset values without a clock edge, and no stale entry reappears after release.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: formats committed stores into byte lanes and drains them
// in order to the data-memory port; flags loads hitting a pending word.
// Ports:
//   clk, rst                   clock, async active-high reset
//   st_valid/st_kind/st_paddr  store from the MEM stage
//   st_wdata/st_uncached       store data and port select
//   st_ready                   room for a store this cycle
//   bus_req/bus_addr           head entry presented to memory
//   bus_wrdata/bus_byteenable  head lane data and enables
//   bus_uncached/bus_ack       head port flag, memory accept
//   load_paddr/load_hit        word-address hazard check
//   empty/count                occupancy
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [2:0]                 st_kind,
  input  logic [31:0]                st_paddr,
  input  logic [31:0]                st_wdata,
  input  logic                       st_uncached,
  output logic                       st_ready,
  output logic                       bus_req,
  output logic [31:0]                bus_addr,
  output logic [31:0]                bus_wrdata,
  output logic [3:0]                 bus_byteenable,
  output logic                       bus_uncached,
  input  logic                       bus_ack,
  input  logic [31:0]                load_paddr,
  output logic                       load_hit,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] K_SB  = 3'd0;
  localparam logic [2:0] K_SH  = 3'd1;
  localparam logic [2:0] K_SWL = 3'd3;
  localparam logic [2:0] K_SWR = 3'd4;

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic          unc_q  [DEPTH];
  logic          vld_q  [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    off;
  logic [3:0]    fmt_be;
  logic [31:0]   fmt_data;
  logic          push, pop;
  logic          unused_ok;

  assign unused_ok = ^load_paddr[1:0];

  // Lane formatting of the incoming store.
  assign off = st_paddr[1:0];

  always_comb begin
    fmt_be   = 4'b1111;
    fmt_data = st_wdata;
    unique case (st_kind)
      K_SB: begin
        fmt_be   = 4'b0001 << off;
        fmt_data = {4{st_wdata[7:0]}};
      end
      K_SH: begin
        fmt_be   = off[1] ? 4'b1100 : 4'b0011;
        fmt_data = {2{st_wdata[15:0]}};
      end
      K_SWL: begin
        // (2 << off) - 1 wraps to 1111 at off=3
        fmt_be   = (4'b0010 << off) - 4'b0001;
        fmt_data = st_wdata >> {~off, 3'b000};
      end
      K_SWR: begin
        fmt_be   = 4'b1111 << off;
        fmt_data = st_wdata << {off, 3'b000};
      end
      default: begin
        fmt_be   = 4'b1111;
        fmt_data = st_wdata;
      end
    endcase
  end

  // Occupancy and handshakes come from registered state only.
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign st_ready = (count_q < CW'(DEPTH));
  assign bus_req  = !empty;
  assign push     = st_valid && st_ready;
  assign pop      = bus_req && bus_ack;

  assign bus_addr       = empty ? '0 : {addr_q[rptr_q], 2'b00};
  assign bus_wrdata     = empty ? '0 : data_q[rptr_q];
  assign bus_byteenable = empty ? '0 : be_q[rptr_q];
  assign bus_uncached   = empty ? 1'b0 : unc_q[rptr_q];

  always_comb begin
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A store pushed this cycle is not yet in vld_q, so it never hits.
  always_comb begin
    load_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == load_paddr[31:2])) begin
        load_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
        unc_q[i]  <= 1'b0;
      end
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      // push and pop can never address the same slot
      if (pop) begin
        vld_q[rptr_q] <= 1'b0;
      end
      if (push) begin
        vld_q[wptr_q]  <= 1'b1;
        addr_q[wptr_q] <= st_paddr[31:2];
        data_q[wptr_q] <= fmt_data;
        be_q[wptr_q]   <= fmt_be;
        unc_q[wptr_q]  <= st_uncached;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer
// against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [2:0]  st_kind = '0;
  logic [31:0] st_paddr = '0;
  logic [31:0] st_wdata = '0;
  logic        st_uncached = 1'b0;
  logic        st_ready;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic [3:0]  bus_byteenable;
  logic        bus_uncached;
  logic        bus_ack = 1'b0;
  logic [31:0] load_paddr = '0;
  logic        load_hit;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        u;
  } ent_t;

  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_kind(st_kind),
    .st_paddr(st_paddr), .st_wdata(st_wdata),
    .st_uncached(st_uncached), .st_ready(st_ready),
    .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_wrdata(bus_wrdata),
    .bus_byteenable(bus_byteenable),
    .bus_uncached(bus_uncached), .bus_ack(bus_ack),
    .load_paddr(load_paddr), .load_hit(load_hit),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Reference formatting from the lane rules, in integer arithmetic.
  function automatic void fmt(input logic [2:0] k,
                              input logic [1:0] off,
                              input logic [31:0] r,
                              output logic [31:0] d,
                              output logic [3:0] be);
    int o;
    o = int'(off);
    case (k)
      3'd0: begin be = 4'(1 << o); d = {4{r[7:0]}}; end
      3'd1: begin
        be = (o >= 2) ? 4'hC : 4'h3;
        d  = {2{r[15:0]}};
      end
      3'd3: begin be = 4'((2 << o) - 1); d = r >> (8 * (3 - o)); end
      3'd4: begin be = 4'(15 << o); d = r << (8 * o); end
      default: begin be = 4'hF; d = r; end
    endcase
  endfunction

  task automatic idle();
    st_valid = 1'b0;
    bus_ack  = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 ||
        bus_req !== 1'b0 || load_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got cnt=%0d e=%b r=%b q=%b h=%b",
               count, empty, st_ready, bus_req, load_hit);
    end
    checks++;
    if (bus_addr !== 0 || bus_wrdata !== 0 ||
        bus_byteenable !== 0 || bus_uncached !== 0) begin
      errors++;
      $display("FAIL reset_bus got a=%h d=%h be=%b u=%b exp zeros",
               bus_addr, bus_wrdata, bus_byteenable, bus_uncached);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sb();
    reset_dut();
    @(negedge clk);
    st_valid = 1'b1; st_kind = 3'd0;
    st_paddr = 32'h1000_0003; st_wdata = 32'hAABB_CCDD;
    st_uncached = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h1000_0000 ||
        bus_byteenable !== 4'b1000 || bus_wrdata !== 32'hDDDD_DDDD ||
        bus_uncached !== 1'b1) begin
      errors++;
      $display("FAIL sb_head got q=%b a=%h be=%b d=%h u=%b",
               bus_req, bus_addr, bus_byteenable, bus_wrdata, bus_uncached);
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || bus_req !== 1'b0 || bus_addr !== 0) begin
      errors++;
      $display("FAIL sb_drain got e=%b q=%b a=%h exp 1 0 0",
               empty, bus_req, bus_addr);
    end
  endtask

  task automatic test_swl_swr();
    logic [3:0]  lbe [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [31:0] ld  [4] = '{32'h0000_0011, 32'h0000_1122,
                             32'h0011_2233, 32'h1122_3344};
    logic [3:0]  rbe [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [31:0] rd  [4] = '{32'h1122_3344, 32'h2233_4400,
                             32'h3344_0000, 32'h4400_0000};
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      for (int o = 0; o < 4; o++) begin
        @(negedge clk);
        st_valid = 1'b1; st_kind = 3'(3 + k);
        st_paddr = 32'h5000_0010 | o; st_wdata = 32'h1122_3344;
        st_uncached = 1'b0;
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        checks++;
        if (bus_addr !== 32'h5000_0010 ||
            bus_byteenable !== (k == 0 ? lbe[o] : rbe[o]) ||
            bus_wrdata !== (k == 0 ? ld[o] : rd[o])) begin
          errors++;
          $display("FAIL %s_off%0d got a=%h be=%b d=%h exp be=%b d=%h",
                   k == 0 ? "swl" : "swr", o, bus_addr, bus_byteenable,
                   bus_wrdata, k == 0 ? lbe[o] : rbe[o],
                   k == 0 ? ld[o] : rd[o]);
        end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
      end
    end
  endtask

  task automatic test_full();
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (st_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_ready%0d got %b exp 1", i, st_ready);
      end
      st_valid = 1'b1; st_kind = 3'd2;
      st_paddr = 32'h4000_0000 + 32'(i * 4); st_wdata = 32'(i + 1);
    end
    @(negedge clk);
    st_wdata = 32'hDEAD_BEEF;
    st_paddr = 32'h4000_0100;
    #1;
    checks++;
    if (count !== 3'd4 || st_ready !== 1'b0 || bus_wrdata !== 32'd1) begin
      errors++;
      $display("FAIL full_state got cnt=%0d r=%b d=%h exp 4 0 1",
               count, st_ready, bus_wrdata);
    end
    @(negedge clk);
    st_valid = 1'b0;
    bus_ack = 1'b1;
    #1;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_reject got cnt=%0d exp 4", count);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++;
    if (st_ready !== 1'b1 || count !== 3'd3) begin
      errors++;
      $display("FAIL full_after_ack got r=%b cnt=%0d exp 1 3",
               st_ready, count);
    end
    for (int k = 2; k <= 4; k++) begin
      checks++;
      if (bus_wrdata !== 32'(k)) begin
        errors++;
        $display("FAIL full_order%0d got %h exp %h", k, bus_wrdata, k);
      end
      bus_ack = 1'b1;
      @(negedge clk);
      #1;
    end
    bus_ack = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full_empty got %b exp 1", empty);
    end
  endtask

  task automatic test_load_hit();
    reset_dut();
    @(negedge clk);
    st_valid = 1'b1; st_kind = 3'd1;
    st_paddr = 32'h2000_0006; st_wdata = 32'h1234_5678;
    load_paddr = 32'h2000_0004;
    #1;
    checks++;
    if (load_hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_push_cycle got %b exp 0", load_hit);
    end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    checks++;
    if (load_hit !== 1'b1 || bus_byteenable !== 4'b1100 ||
        bus_wrdata !== 32'h5678_5678) begin
      errors++;
      $display("FAIL hit_same got h=%b be=%b d=%h exp 1 1100 56785678",
               load_hit, bus_byteenable, bus_wrdata);
    end
    load_paddr = 32'h2000_0008;
    #1;
    checks++;
    if (load_hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_other got %b exp 0", load_hit);
    end
    load_paddr = 32'h2000_0004;
    bus_ack = 1'b1;
    #1;
    checks++;
    if (load_hit !== 1'b1) begin
      errors++;
      $display("FAIL hit_ack_cycle got %b exp 1", load_hit);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++;
    if (load_hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_after_ack got %b exp 0", load_hit);
    end
  endtask

  task automatic run_stream(input int cycles, input bit always_on);
    logic [31:0] d;
    logic [3:0]  be;
    logic        hit;
    bit          do_push, do_pop;
    ent_t        e;
    reset_dut();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      st_valid    = always_on ? 1'b1 : ($urandom_range(0, 9) < 7);
      st_kind     = 3'($urandom_range(0, 7));
      st_paddr    = 32'h3000_0000 + 32'($urandom_range(0, 15) << 2)
                    + 32'($urandom_range(0, 3));
      st_wdata    = $urandom;
      st_uncached = 1'($urandom_range(0, 1));
      bus_ack     = always_on ? 1'b1 : 1'($urandom_range(0, 1));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        load_paddr = {q[$urandom_range(0, q.size() - 1)].a,
                      2'($urandom_range(0, 3))};
      end else begin
        load_paddr = 32'h3000_0000 + 32'($urandom_range(0, 15) << 2);
      end
      #1;
      hit = 1'b0;
      foreach (q[i]) if (q[i].a == load_paddr[31:2]) hit = 1'b1;
      checks++;
      if (count !== 3'(q.size()) || empty !== (q.size() == 0) ||
          st_ready !== (q.size() < DEPTH) || load_hit !== hit) begin
        errors++;
        $display("FAIL stream_state c=%0d got cnt=%0d r=%b h=%b exp %0d %b",
                 c, count, st_ready, load_hit, q.size(), hit);
      end
      checks++;
      if (q.size() == 0) begin
        if (bus_req !== 1'b0 || bus_addr !== 0 || bus_wrdata !== 0 ||
            bus_byteenable !== 0 || bus_uncached !== 0) begin
          errors++;
          $display("FAIL stream_idle c=%0d got q=%b a=%h d=%h be=%b",
                   c, bus_req, bus_addr, bus_wrdata, bus_byteenable);
        end
      end else if (bus_req !== 1'b1 || bus_addr !== {q[0].a, 2'b00} ||
                   bus_wrdata !== q[0].d || bus_byteenable !== q[0].be ||
                   bus_uncached !== q[0].u) begin
        errors++;
        $display("FAIL stream_head c=%0d got a=%h d=%h be=%b exp %h %h %b",
                 c, bus_addr, bus_wrdata, bus_byteenable,
                 {q[0].a, 2'b00}, q[0].d, q[0].be);
      end
      if (always_on) begin
        checks++;
        if (count > 3'd1) begin
          errors++;
          $display("FAIL stream_stay_low got %0d exp <=1", count);
        end
      end
      do_pop  = bus_ack && q.size() > 0;
      do_push = st_valid && q.size() < DEPTH;
      fmt(st_kind, st_paddr[1:0], st_wdata, d, be);
      e = '{a: st_paddr[31:2], d: d, be: be, u: st_uncached};
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    run_stream(3 * DEPTH + 4, 1'b1);
  endtask

  task automatic test_random();
    run_stream(300, 1'b0);
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      st_valid = 1'b1; st_kind = 3'd2;
      st_paddr = 32'h6000_0000 + 32'(i * 4); st_wdata = 32'hA0 + 32'(i);
    end
    @(negedge clk);
    st_valid = 1'b0;
    bus_ack = 1'b1;
    load_paddr = 32'h6000_0000;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1 ||
        bus_req !== 1'b0 || load_hit !== 1'b0 || bus_addr !== 0 ||
        bus_wrdata !== 0 || bus_byteenable !== 0) begin
      errors++;
      $display("FAIL async_rst got cnt=%0d q=%b h=%b a=%h d=%h be=%b",
               count, bus_req, load_hit, bus_addr, bus_wrdata,
               bus_byteenable);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || load_hit !== 1'b0) begin
      errors++;
      $display("FAIL async_release got e=%b h=%b exp 1 0", empty, load_hit);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    st_valid = 1'b1; st_kind = 3'd2;
    st_paddr = 32'h7000_0000; st_wdata = 32'h5555_AAAA;
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd1 || bus_addr !== 32'h7000_0000 ||
        bus_wrdata !== 32'h5555_AAAA || load_hit !== 1'b0) begin
      errors++;
      $display("FAIL async_stale got cnt=%0d a=%h d=%h h=%b",
               count, bus_addr, bus_wrdata, load_hit);
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_swl_swr();
    test_full();
    test_load_hit();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
